// File: rtl/i2c_slave.sv
// I2C target with 7-bit addressing, byte-wise write and read transfers.
// Bus lines are oversampled on i_sclk; SDA is driven open-drain through o_sda_oe.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       i_sclk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, IGNORE, WRITE, WRITE_ACK, READ, READ_ACK
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] shreg;
  logic       rw;

  // [0],[1] form the synchronizer, [2] is the delayed copy used for edge detection.
  // Reset to 1 so an idle bus produces no spurious events after reset release.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], i_scl};
      sda_q <= {sda_q[1:0], i_sda};
    end
  end

  logic scl_s, scl_d, sda_s, sda_d;
  logic scl_rise, scl_fall, start_evt, stop_evt;

  assign scl_s     = scl_q[1];
  assign scl_d     = scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_d     = sda_q[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign stop_evt  = scl_s & scl_d & sda_s & ~sda_d;
  assign start_evt = scl_s & scl_d & ~sda_s & sda_d;
  assign o_state   = state;

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      shreg      <= 8'd0;
      rw         <= 1'b0;
      o_sda_oe   <= 1'b0;
      o_tx_req   <= 1'b0;
      o_rx_data  <= 8'd0;
      o_rx_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_tx_req   <= 1'b0;
      o_rx_valid <= 1'b0;
      if (stop_evt) begin
        state    <= IDLE;
        o_sda_oe <= 1'b0;
        o_busy   <= 1'b0;
      end else if (start_evt) begin
        state    <= ADDR;
        cnt      <= 4'd0;
        o_sda_oe <= 1'b0;
        o_busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_s};
              cnt   <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              if (shreg[7:1] == SLAVE_ADDR) begin
                o_sda_oe <= 1'b1;
                o_busy   <= 1'b1;
                rw       <= shreg[0];
                state    <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              cnt <= 4'd0;
              if (!rw) begin
                o_sda_oe <= 1'b0;
                state    <= WRITE;
              end else begin
                shreg    <= i_tx_data;
                o_tx_req <= 1'b1;
                o_sda_oe <= ~i_tx_data[7];
                state    <= READ;
              end
            end
          end
          IGNORE: o_sda_oe <= 1'b0;
          WRITE: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_s};
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                o_rx_data  <= {shreg[6:0], sda_s};
                o_rx_valid <= 1'b1;
              end
            end else if (scl_fall && cnt == 4'd8) begin
              o_sda_oe <= 1'b1;
              state    <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              o_sda_oe <= 1'b0;
              cnt      <= 4'd0;
              state    <= WRITE;
            end
          end
          READ: begin
            // Bit 7 was already driven on entry; each fall moves to the next bit.
            if (scl_fall) begin
              if (cnt == 4'd7) begin
                o_sda_oe <= 1'b0;
                cnt      <= 4'd0;
                state    <= READ_ACK;
              end else begin
                shreg    <= {shreg[6:0], 1'b0};
                o_sda_oe <= ~shreg[6];
                cnt      <= cnt + 4'd1;
              end
            end
          end
          READ_ACK: begin
            // cnt==1 records that the master acknowledged on this clock.
            if (scl_rise) begin
              if (sda_s) begin
                o_busy <= 1'b0;
                state  <= IGNORE;
              end else begin
                cnt <= 4'd1;
              end
            end else if (scl_fall && cnt == 4'd1) begin
              shreg    <= i_tx_data;
              o_tx_req <= 1'b1;
              o_sda_oe <= ~i_tx_data[7];
              cnt      <= 4'd0;
              state    <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) that answers the bus master built in this codebase: 7-bit addressing, byte-wise write and read transfers, ACK/NACK, repeated START and STOP.
- Bus lines are oversampled on the inner system clock; SDA is driven open-drain through an output-enable (1 = pull low).
- Received bytes go out on a valid-strobe interface; transmit bytes come from a request-strobe interface.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this target responds to.

Ports:
- i_sclk  input  1  inner system clock; all logic on its rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_scl  input  1  bus SCL as seen on the wire (asynchronous to i_sclk).
- i_sda  input  1  bus SDA as seen on the wire (asynchronous to i_sclk).
- o_sda_oe  output  1  1 = pull SDA low; 0 = release.
- i_tx_data  input  8  byte returned to the master on a read; sampled when o_tx_req pulses.
- o_tx_req  output  1  one-cycle pulse: i_tx_data has been loaded.
- o_rx_data  output  8  last byte written by the master.
- o_rx_valid  output  1  one-cycle pulse: o_rx_data has been updated.
- o_busy  output  1  high from address match until STOP or release.

Behaviour:
- Reset: state IDLE, bit counter 0, shift register 0; o_sda_oe=0, o_tx_req=0, o_rx_valid=0, o_rx_data=0, o_busy=0.
- Input conditioning: i_scl and i_sda each pass through a 2-flop synchronizer plus one delayed copy. All edges are detected on synchronized values, so bus events are seen 3 i_sclk cycles late.
- Required bus timing: SCL high and low phases each >= 8 i_sclk cycles.
- Bus events, in priority order:
  - STOP: SDA rises while SCL is high.
  - START: SDA falls while SCL is high.
  - SCL rise: sample point.
  - SCL fall: drive-change point.
- Bus events on SDA take priority over everything else in any state:
  - START, including a repeated START: go to ADDR, counter=0, o_sda_oe=0, o_busy=0.
  - STOP: go to IDLE, o_sda_oe=0, o_busy=0.
- IDLE: ignore SCL; wait for START.
- ADDR:
  - On each SCL rise, shift SDA into shreg (MSB first) and increment the counter.
  - On the SCL fall after the 8th rise:
    - If shreg[7:1]==SLAVE_ADDR: o_sda_oe=1 (ACK), o_busy=1, latch R/W=shreg[0], go to ADDR_ACK.
    - Otherwise: go to IGNORE.
- IGNORE: o_sda_oe=0; leave only on START or STOP.
- ADDR_ACK, on the SCL fall ending the ACK clock, counter=0:
  - R/W=0: o_sda_oe=0, go to WRITE.
  - R/W=1: load i_tx_data into shreg, pulse o_tx_req, o_sda_oe=~i_tx_data[7], go to READ.
- WRITE:
  - On each SCL rise, shift SDA into shreg.
  - On the 8th rise: o_rx_data<=new byte and o_rx_valid=1 for exactly one cycle.
  - On the next SCL fall: o_sda_oe=1 (ACK), go to WRITE_ACK.
- WRITE_ACK: on SCL fall, o_sda_oe=0, counter=0, go to WRITE. There is no byte limit.
- READ:
  - On each SCL fall after a bit: shift out the next bit, o_sda_oe=~bit.
  - On the fall after bit 0: o_sda_oe=0, go to READ_ACK.
- READ_ACK, on SCL rise, sample SDA:
  - 0 (ACK): on the next fall, reload i_tx_data, pulse o_tx_req, drive MSB, counter=0, go to READ.
  - 1 (NACK): o_busy=0, go to IGNORE.
- o_sda_oe changes only on an SCL fall, a START/STOP event or reset. It never changes while synchronized SCL is high.
- STOP or START in mid-byte: the partial byte is discarded and no o_rx_valid fires.
- Reset asserted mid-transfer: all outputs go to their reset values immediately and SDA is released.

Test Plan:
- Write to 0x42 with data 0xA5, then STOP -> ACK (o_sda_oe=1) during the 9th and 18th SCL; o_rx_valid pulses once with o_rx_data=0xA5; o_busy=0 after STOP.
- Address 0x43, write -> o_sda_oe stays 0 for the whole transfer; o_rx_valid never fires; o_busy stays 0.
- Read from 0x42 with i_tx_data=0x3C, master NACK -> SDA bits 0,0,1,1,1,1,0,0; one o_tx_req pulse; SDA released; IGNORE state until STOP.
- Two-byte read with i_tx_data 0x81 then 0x7E, master ACK then NACK -> two o_tx_req pulses; SDA bits 10000001 then 01111110.
- Write 0x42, send 4 data bits, repeated START, then read 0x42 -> no o_rx_valid; ACK for the new address; read proceeds normally.
- Pull i_rst_n low during the 5th bit of a read byte -> o_sda_oe=0 asynchronously; after release, stays idle until the next START.
